// File: rtl/polymul_job_ctrl_if.sv
// Bundles the command, status, DMA-stream and core-side signals of the polymul job controller.
// The slave modport is the controller's view; the master modport is its environment.
interface polymul_job_ctrl_if #(
  parameter int CYC_W = 32
);
  logic             start;
  logic             abort;
  logic [9:0]       cfg_n;
  logic [1:0]       cfg_q;
  logic             busy;
  logic             done;
  logic             err;
  logic [2:0]       err_code;
  logic [CYC_W-1:0] cycles;
  logic [31:0]      s_tdata;
  logic             s_tvalid;
  logic             s_tlast;
  logic             s_tready;
  logic [12:0]      core_in_poly_1;
  logic [1:0]       core_in_poly_2;
  logic             core_in_valid;
  logic             core_in_ready;
  logic [12:0]      core_out;
  logic             core_out_valid;
  logic             core_out_ready;
  logic             core_done;
  logic [9:0]       core_poly_n;
  logic [1:0]       core_poly_q;
  logic             core_soft_rst;
  logic [31:0]      m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;

  modport slave (
    input  start, abort, cfg_n, cfg_q,
    output busy, done, err, err_code, cycles,
    input  s_tdata, s_tvalid, s_tlast,
    output s_tready,
    output core_in_poly_1, core_in_poly_2, core_in_valid,
    input  core_in_ready,
    input  core_out, core_out_valid, core_done,
    output core_out_ready, core_poly_n, core_poly_q, core_soft_rst,
    output m_tdata, m_tvalid, m_tlast,
    input  m_tready
  );

  modport master (
    output start, abort, cfg_n, cfg_q,
    input  busy, done, err, err_code, cycles,
    output s_tdata, s_tvalid, s_tlast,
    input  s_tready,
    input  core_in_poly_1, core_in_poly_2, core_in_valid,
    output core_in_ready,
    output core_out, core_out_valid, core_done,
    input  core_out_ready, core_poly_n, core_poly_q, core_soft_rst,
    input  m_tdata, m_tvalid, m_tlast,
    output m_tready
  );
endinterface

// File: rtl/polymul_job_ctrl.sv
// Job sequencer between the AXI-stream DMA ports and the polymul core: gates n input beats,
// forwards n result beats with a self-generated tlast, checks core alignment, times the job.
module polymul_job_ctrl #(
  parameter int N_MAX = 821,
  parameter int CYC_W = 32
) (
  input  logic               clk,
  input  logic               resetn,
  polymul_job_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_WAIT_OUT = 2'd2,
    ST_UNLOAD   = 2'd3
  } state_t;

  localparam logic [9:0] N_MAX_C = 10'(N_MAX);

  state_t           state_q, state_d;
  logic [9:0]       n_q, n_d;
  logic [1:0]       q_q, q_d;
  logic [9:0]       in_cnt_q, in_cnt_d;
  logic [9:0]       out_cnt_q, out_cnt_d;
  logic             err_q, err_d;
  logic [2:0]       err_code_q, err_code_d;
  logic             done_q, done_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic [1:0]       srst_cnt_q, srst_cnt_d;

  logic       cfg_ok_s;
  logic [9:0] n_m1_s;
  logic       in_beat_s;
  logic       in_last_s;
  logic       out_beat_s;
  logic       out_last_s;
  logic       unused_s;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CYC_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign cfg_ok_s   = (bus.cfg_n != 10'd0) && (bus.cfg_n <= N_MAX_C);
  assign n_m1_s     = n_q - 10'd1;
  assign in_beat_s  = (state_q == ST_LOAD) && bus.s_tvalid && bus.core_in_ready;
  assign in_last_s  = (in_cnt_q == n_m1_s);
  assign out_beat_s = (state_q == ST_UNLOAD) && bus.core_out_valid && bus.m_tready;
  assign out_last_s = (out_cnt_q == n_m1_s);

  // Handshake pass-through is combinational so the stream sees no extra latency.
  always_comb begin
    bus.s_tready       = 1'b0;
    bus.core_in_valid  = 1'b0;
    bus.core_out_ready = 1'b0;
    bus.m_tvalid       = 1'b0;
    bus.m_tlast        = 1'b0;
    case (state_q)
      ST_LOAD: begin
        bus.core_in_valid = bus.s_tvalid;
        bus.s_tready      = bus.core_in_ready;
      end
      ST_UNLOAD: begin
        bus.m_tvalid       = bus.core_out_valid;
        bus.core_out_ready = bus.m_tready;
        bus.m_tlast        = out_last_s && bus.core_out_valid;
      end
      default: begin
        bus.s_tready = 1'b0;
      end
    endcase
  end

  // Next-state, counters, error flags and job timer.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    q_d        = q_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    cycles_d   = cycles_q;
    srst_cnt_d = (srst_cnt_q == 2'd0) ? 2'd0 : (srst_cnt_q - 2'd1);

    if (state_q != ST_IDLE) begin
      cycles_d = sat_inc(cycles_q);
    end else begin
      cycles_d = cycles_q;
    end

    if ((state_q != ST_IDLE) && bus.abort) begin
      state_d    = ST_IDLE;
      srst_cnt_d = 2'd2;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && cfg_ok_s) begin
            n_d        = bus.cfg_n;
            q_d        = bus.cfg_q;
            err_d      = 1'b0;
            err_code_d = 3'b000;
            cycles_d   = {CYC_W{1'b0}};
            in_cnt_d   = 10'd0;
            out_cnt_d  = 10'd0;
            state_d    = ST_LOAD;
          end else if (bus.start) begin
            err_d         = 1'b1;
            err_code_d[0] = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (in_beat_s) begin
            in_cnt_d = in_cnt_q + 10'd1;
            if (bus.s_tlast && !in_last_s) begin
              err_d         = 1'b1;
              err_code_d[1] = 1'b1;
            end else begin
              err_d = err_q;
            end
            if (in_last_s) begin
              state_d = ST_WAIT_OUT;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_WAIT_OUT: begin
          if (bus.core_out_valid) begin
            state_d = ST_UNLOAD;
          end else begin
            state_d = ST_WAIT_OUT;
          end
        end
        ST_UNLOAD: begin
          if (out_beat_s) begin
            out_cnt_d = out_cnt_q + 10'd1;
            if (bus.core_done != out_last_s) begin
              err_d         = 1'b1;
              err_code_d[2] = 1'b1;
            end else begin
              err_d = err_q;
            end
            // The timer already includes the done cycle when done becomes visible.
            if (out_last_s) begin
              done_d   = 1'b1;
              cycles_d = sat_inc(sat_inc(cycles_q));
              state_d  = ST_IDLE;
            end else begin
              state_d = ST_UNLOAD;
            end
          end else begin
            state_d = ST_UNLOAD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and status registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      n_q        <= 10'd0;
      q_q        <= 2'd0;
      in_cnt_q   <= 10'd0;
      out_cnt_q  <= 10'd0;
      err_q      <= 1'b0;
      err_code_q <= 3'b000;
      done_q     <= 1'b0;
      cycles_q   <= {CYC_W{1'b0}};
      srst_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      q_q        <= q_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
      cycles_q   <= cycles_d;
      srst_cnt_q <= srst_cnt_d;
    end
  end

  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.err_code       = err_code_q;
  assign bus.cycles         = cycles_q;
  assign bus.core_poly_n    = n_q;
  assign bus.core_poly_q    = q_q;
  assign bus.core_soft_rst  = (srst_cnt_q != 2'd0);
  assign bus.core_in_poly_1 = bus.s_tdata[12:0];
  assign bus.core_in_poly_2 = bus.s_tdata[17:16];
  assign bus.m_tdata        = {19'd0, bus.core_out};
  assign unused_s           = ^{bus.s_tdata[31:18], bus.s_tdata[15:13]};

endmodule

// File: tb/tb_polymul_job_ctrl.sv
// Directed job sequence with random stalls; the bench plays DMA source, polymul core and DMA sink
// and predicts every beat, flag and timer value from job-level counts.
module tb_polymul_job_ctrl;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  polymul_job_ctrl_if #(.CYC_W(32)) bus ();

  polymul_job_ctrl #(.N_MAX(821), .CYC_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rnd(input int stall);
    return ($urandom_range(99) >= stall);
  endfunction

  task automatic idle_inputs();
    bus.start          = 1'b0;
    bus.abort          = 1'b0;
    bus.s_tvalid       = 1'b0;
    bus.s_tlast        = 1'b0;
    bus.core_in_ready  = 1'b0;
    bus.core_out_valid = 1'b0;
    bus.core_done      = 1'b0;
    bus.m_tready       = 1'b0;
  endtask

  // One job: tlast_at / done_at are the beat indices carrying those flags (-1 = none),
  // abort_at is the accepted-beat count at which abort is raised (-1 = never).
  task automatic run_job(input int n, input int q, input int tlast_at, input int done_at,
                         input int abort_at, input int stall, input logic start_abort);
    logic [12:0] p1 [1024];
    logic [1:0]  p2 [1024];
    logic [12:0] res [1024];
    int src_idx = 0, rx_idx = 0, out_idx = 0, snk_idx = 0;
    int last_cyc = -1, abort_cyc = -1, done_cnt = 0;
    int viol = 0, dviol = 0, lviol = 0;
    int budget = 10 * n + 200;
    int cyc;
    logic wait_seen = 1'b0, aborted = 1'b0, finished = 1'b0;
    logic loading, unloading, have_res, exp_last;
    logic [2:0] exp_code;
    logic [31:0] final_cycles = 32'd0;

    for (int i = 0; i < 1024; i++) begin
      p1[i]  = 13'($urandom);
      p2[i]  = 2'($urandom);
      res[i] = 13'($urandom);
    end
    exp_code = 3'b000;
    if (tlast_at >= 0 && tlast_at != n - 1 && (abort_at < 0 || tlast_at < abort_at)) exp_code[1] = 1'b1;
    if (abort_at < 0 && done_at != n - 1) exp_code[2] = 1'b1;

    for (cyc = 0; cyc < budget && !finished; cyc++) begin
      @(posedge clk); #1;
      if (cyc >= 1 && bus.done === 1'b1) done_cnt++;
      if (cyc == 1) begin
        chk("busy_after_start", bus.busy, 1);
        chk("err_cleared", bus.err, 0);
        chk("err_code_cleared", bus.err_code, 0);
        chk("cycles_cleared", bus.cycles, 0);
        chk("poly_n_latched", bus.core_poly_n, n);
        chk("poly_q_latched", bus.core_poly_q, q);
        chk("soft_rst_low", bus.core_soft_rst, 0);
      end
      if (aborted) begin
        if (cyc == abort_cyc + 1) begin
          chk("abort_idle", bus.busy, 0);
          chk("abort_srst_1", bus.core_soft_rst, 1);
          chk("abort_hs_drop", {bus.s_tready, bus.core_in_valid, bus.m_tvalid}, 0);
        end else if (cyc == abort_cyc + 2) begin
          chk("abort_srst_2", bus.core_soft_rst, 1);
        end else if (cyc == abort_cyc + 3) begin
          chk("abort_srst_end", bus.core_soft_rst, 0);
          chk("abort_still_idle", bus.busy, 0);
          chk("abort_err_kept", bus.err, (exp_code != 3'b000));
          chk("abort_err_code", bus.err_code, exp_code);
          finished = 1'b1;
        end
      end else if (last_cyc >= 0 && cyc == last_cyc + 1) begin
        chk("done_pulse", bus.done, 1);
        chk("cycles_at_done", bus.cycles, cyc);
        chk("idle_at_done", bus.busy, 0);
        final_cycles = bus.cycles;
        finished = 1'b1;
      end

      if (finished || aborted) begin
        idle_inputs();
      end else begin
        loading   = (cyc >= 1) && (src_idx < n);
        have_res  = (rx_idx == n);
        unloading = wait_seen && (out_idx < n);
        bus.start = (cyc == 0);
        bus.abort = (cyc == 0) ? start_abort : 1'b0;
        bus.cfg_n = 10'(n);
        bus.cfg_q = 2'(q);
        bus.s_tvalid = loading && rnd(stall);
        bus.s_tdata  = {14'd0, p2[src_idx], 3'd0, p1[src_idx]};
        bus.s_tlast  = (src_idx == tlast_at);
        if (abort_at >= 0 && cyc >= 1 && src_idx == abort_at) begin
          bus.abort    = 1'b1;
          bus.s_tvalid = 1'b0;
          aborted      = 1'b1;
          abort_cyc    = cyc;
        end
        bus.core_in_ready  = rnd(stall);
        bus.core_out_valid = have_res && (out_idx < n) && rnd(stall);
        bus.core_out       = res[out_idx];
        bus.core_done      = (out_idx == done_at);
        bus.m_tready       = rnd(stall);
        #1;
        if (bus.core_in_valid !== (loading && bus.s_tvalid)) viol++;
        if (bus.s_tready !== (loading && bus.core_in_ready)) viol++;
        if (bus.m_tvalid !== (unloading && bus.core_out_valid)) viol++;
        if (bus.core_out_ready !== (unloading && bus.m_tready)) viol++;
        exp_last = unloading && bus.core_out_valid && (snk_idx == n - 1);
        if (bus.m_tlast !== exp_last) lviol++;
        if (bus.s_tvalid && bus.s_tready) src_idx++;
        if (bus.core_in_valid && bus.core_in_ready) begin
          if (bus.core_in_poly_1 !== p1[rx_idx] || bus.core_in_poly_2 !== p2[rx_idx]) dviol++;
          rx_idx++;
        end
        if (bus.core_out_valid && bus.core_out_ready) out_idx++;
        if (bus.m_tvalid && bus.m_tready) begin
          if (bus.m_tdata !== {19'd0, res[snk_idx]}) dviol++;
          if (snk_idx == n - 1) last_cyc = cyc;
          snk_idx++;
        end
        if (have_res && !wait_seen && bus.core_out_valid) wait_seen = 1'b1;
      end
    end

    chk("job_finished_in_budget", finished, 1);
    chk("in_beats", src_idx, (abort_at >= 0) ? abort_at : n);
    chk("core_rx_beats", rx_idx, (abort_at >= 0) ? abort_at : n);
    chk("handshake_gating", viol, 0);
    chk("data_order", dviol, 0);
    chk("tlast_position", lviol, 0);
    chk("done_count", done_cnt, (abort_at >= 0) ? 0 : 1);
    if (abort_at < 0) begin
      chk("out_beats", snk_idx, n);
      chk("err_flag", bus.err, (exp_code != 3'b000));
      chk("err_code", bus.err_code, exp_code);
      @(posedge clk); #1;
      chk("done_one_cycle", bus.done, 0);
      chk("cycles_held", bus.cycles, final_cycles);
    end else begin
      chk("no_out_beats", snk_idx, 0);
    end
    idle_inputs();
  endtask

  task automatic bad_cfg(input int v);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.cfg_n = 10'(v);
    bus.cfg_q = 2'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("bad_cfg_busy", bus.busy, 0);
    chk("bad_cfg_err", bus.err, 1);
    chk("bad_cfg_code", bus.err_code, 3'b001);
    @(posedge clk); #1;
    chk("bad_cfg_stay_idle", bus.busy, 0);
  endtask

  initial begin
    resetn    = 1'b0;
    bus.cfg_n = 10'd0;
    bus.cfg_q = 2'd0;
    bus.s_tdata = 32'd0;
    bus.core_out = 13'd0;
    idle_inputs();
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_err_code", bus.err_code, 0);
    chk("rst_cycles", bus.cycles, 0);
    chk("rst_poly_n", bus.core_poly_n, 0);
    chk("rst_poly_q", bus.core_poly_q, 0);
    chk("rst_soft_rst", bus.core_soft_rst, 0);
    chk("rst_handshakes", {bus.s_tready, bus.core_in_valid, bus.core_out_ready, bus.m_tvalid, bus.m_tlast}, 0);
    chk("rst_m_tdata", bus.m_tdata, 0);
    #5 resetn = 1'b1;

    run_job(509, 0, 508, 508, -1, 0, 1'b0);
    run_job(677, 2, 676, 676, -1, 30, 1'b0);
    bad_cfg(0);
    bad_cfg(822);
    run_job(701, 1, 100, 700, -1, 20, 1'b0);
    run_job(821, 3, 820, 819, -1, 10, 1'b0);
    run_job(600, 1, -1, 599, 300, 20, 1'b0);
    run_job(509, 2, 508, 508, -1, 25, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
